// File: rtl/sdram_pf_pkg.sv
// Shared types and default widths for the SDRAM line prefetcher.
package sdram_pf_pkg;

    localparam int PF_DATA_W     = 16;
    localparam int PF_ADDR_W     = 32;
    localparam int PF_LEN_W      = 16;
    localparam int PF_FIFO_DEPTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        WAIT,
        FIN
    } pf_state_t;

endpackage

// File: rtl/sdram_pf_fifo.sv
// Show-ahead FIFO: the head word is presented on rd_data whenever the FIFO is
// not empty. Pops while empty and pushes while full (without a pop) are dropped.
module sdram_pf_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [LVL_W-1:0]  level,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array; no reset needed because rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sdram_line_prefetch.sv
// Sequential single-word read master in front of the SDRAM Wishbone bridge.
// One read is in flight at a time and a read is only issued when the FIFO has
// a free slot, so a returned word always fits.
module sdram_line_prefetch
    import sdram_pf_pkg::*;
#(
    parameter int DATA_W     = PF_DATA_W,
    parameter int ADDR_W     = PF_ADDR_W,
    parameter int LEN_W      = PF_LEN_W,
    parameter int FIFO_DEPTH = PF_FIFO_DEPTH,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    input  logic [DATA_W-1:0] m_dat_i,
    input  logic              m_cyc_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              valid_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              underflow_o
);

    pf_state_t         state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              abort_pend;
    logic              fifo_push;
    logic              fifo_empty;
    logic              fifo_full;
    logic              start_ok;

    assign m_we_o    = 1'b0;
    assign valid_o   = !fifo_empty;
    assign start_ok  = (state == IDLE) && start_i;
    assign fifo_push = (state == WAIT) && !m_cyc_i;

    sdram_pf_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (fifo_push),
        .wr_data (m_dat_i),
        .pop     (pop_i),
        .rd_data (dat_o),
        .level   (level_o),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Transfer FSM with registered bus strobe/address, busy flag and done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            abort_pend <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            m_stb_o    <= 1'b0;
            m_addr_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        addr       <= base_addr_i;
                        remaining  <= len_i;
                        abort_pend <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= (len_i == '0) ? FIN : CHECK;
                    end
                end
                CHECK: begin
                    if (abort_i) begin
                        state <= FIN;
                    end else if (!fifo_full) begin
                        m_stb_o  <= 1'b1;
                        m_addr_o <= addr;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (abort_i) begin
                        abort_pend <= 1'b1;
                    end
                    if (m_cyc_i) begin
                        m_stb_o <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort_i) begin
                        abort_pend <= 1'b1;
                    end
                    if (!m_cyc_i) begin
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if ((remaining == LEN_W'(1)) || abort_pend || abort_i) begin
                            state <= FIN;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                FIN: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky underflow flag: set by a pop on an empty FIFO, cleared by an accepted start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            underflow_o <= 1'b0;
        end else if (start_ok) begin
            underflow_o <= 1'b0;
        end else if (pop_i && fifo_empty) begin
            underflow_o <= 1'b1;
        end
    end

endmodule
